// File: rtl/nn_pkg.sv
// nn_pkg: shared width helpers and FSM state encoding for the nn weight-update slice
package nn_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, APPLY} state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int sat_max(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

endpackage

// File: rtl/nn_signed_popcount.sv
// nn_signed_popcount: signed count of +1/-1 contributions over M product bits
module nn_signed_popcount
    import nn_pkg::*;
#(
    parameter int M  = 4,
    parameter int SW = clog2(M + 1) + 1
) (
    input  logic        [M-1:0]  prod,
    input  logic        [M-1:0]  neg,
    output logic signed [SW-1:0] sum
);

    localparam logic signed [SW-1:0] ONE = 1;

    // add +1 for each positive product, -1 for each negative one
    always_comb begin
        sum = '0;
        for (int i = 0; i < M; i++) sum = sum + (prod[i] ? (neg[i] ? -ONE : ONE) : '0);
    end

endmodule

// File: rtl/nn_conv_wupdate.sv
// nn_conv_wupdate: windowed gradient accumulation, saturating weight step and stochastic weight stream
module nn_conv_wupdate
    import nn_pkg::*;
#(
    parameter int M         = 4,
    parameter int EPOCH_LEN = 16,
    parameter int WIDTH     = 8,
    parameter int LR_SHIFT  = 2,
    parameter int W_INIT    = 0
) (
    input  logic                    CLK,
    input  logic                    INIT,
    input  logic                    EN,
    input  logic        [M-1:0]     delta,
    input  logic        [M-1:0]     SIGN_delta,
    input  logic        [M-1:0]     act,
    input  logic        [M-1:0]     SIGN_act,
    input  logic        [WIDTH-2:0] R,
    output logic signed [WIDTH-1:0] W,
    output logic                    DONE,
    output logic                    alpha,
    output logic                    SIGN_alpha
);

    localparam int SW   = clog2(M + 1) + 1;
    localparam int ACCW = clog2(M * EPOCH_LEN + 1) + 1;
    localparam int CW   = clog2(EPOCH_LEN);
    localparam int UW   = WIDTH + ACCW + 1;
    localparam logic signed [UW-1:0]    HI   = UW'(sat_max(WIDTH));
    localparam logic signed [UW-1:0]    LO   = -HI;
    localparam logic signed [WIDTH-1:0] SMAX = WIDTH'(sat_max(WIDTH));
    localparam logic [CW-1:0]           LAST = CW'(EPOCH_LEN - 1);

    state_t                    state_q, state_d;
    logic signed [ACCW-1:0]    acc_q, acc_d;
    logic        [CW-1:0]      cnt_q, cnt_d;
    logic signed [WIDTH-1:0]   w_d, w_sat;
    logic                      done_d;
    logic signed [SW-1:0]      s;
    logic signed [UW-1:0]      w_wide;
    logic        [WIDTH-1:0]   w_abs;

    nn_signed_popcount #(.M(M), .SW(SW)) u_pop (
        .prod (delta & act),
        .neg  (SIGN_delta ^ SIGN_act),
        .sum  (s)
    );

    // wide subtraction cannot wrap, so clamping afterwards is exact; >>> floors toward -inf
    assign w_wide = UW'(W) - UW'(acc_q >>> LR_SHIFT);
    assign w_sat  = w_wide > HI ? SMAX : w_wide < LO ? -SMAX : w_wide[WIDTH-1:0];
    assign w_abs  = W[WIDTH-1] ? -W : W;

    // FSM state register
    always_ff @(posedge CLK or negedge INIT) begin
        if (!INIT) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // next state and datapath next values: collect a window, then one apply cycle
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        w_d     = W;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (EN) begin
                acc_d   = ACCW'(s);
                cnt_d   = CW'(1);
                state_d = ACCUM;
            end
            ACCUM: if (EN) begin
                acc_d   = acc_q + ACCW'(s);
                cnt_d   = cnt_q + CW'(1);
                state_d = cnt_q == LAST ? APPLY : ACCUM;
            end
            APPLY: begin
                w_d     = w_sat;
                acc_d   = '0;
                cnt_d   = '0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // datapath registers; alpha/SIGN_alpha trail W by one cycle
    always_ff @(posedge CLK or negedge INIT) begin
        if (!INIT) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            W          <= WIDTH'(W_INIT);
            DONE       <= 1'b0;
            alpha      <= 1'b0;
            SIGN_alpha <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            W          <= w_d;
            DONE       <= done_d;
            alpha      <= w_abs > {1'b0, R};
            SIGN_alpha <= W[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_nn_conv_wupdate.sv
// tb_nn_conv_wupdate: randomized scoreboard bench with window-level reference model
module tb_nn_conv_wupdate;

    localparam int LRS  = 2;
    localparam int SMAX = 127;

    typedef struct {
        int cyc;
        int w;
    } exp_t;

    logic              CLK = 1'b0;
    logic              INIT, EN;
    logic        [3:0] delta, SIGN_delta, act, SIGN_act;
    logic        [6:0] R;
    logic signed [7:0] W;
    logic              DONE, alpha, SIGN_alpha;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   r_at[int];
    exp_t sb[$];
    int   wt = 0;
    int   model_w = 0;
    int   prev_w = 0;
    int   last_edge = 0;
    int   r_force = -1;
    logic init_v = 1'b0;

    nn_conv_wupdate #(.M(4), .EPOCH_LEN(16), .WIDTH(8), .LR_SHIFT(LRS), .W_INIT(0)) dut (
        .CLK(CLK), .INIT(INIT), .EN(EN), .delta(delta), .SIGN_delta(SIGN_delta),
        .act(act), .SIGN_act(SIGN_act), .R(R), .W(W), .DONE(DONE),
        .alpha(alpha), .SIGN_alpha(SIGN_alpha)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    // inputs change 2 time units after a rising edge; the next rising edge consumes them
    task automatic drive(input logic en, input logic [3:0] d, sd, a, sa);
        @(posedge CLK);
        #2;
        INIT       = init_v;
        EN         = en;
        delta      = d;
        SIGN_delta = sd;
        act        = a;
        SIGN_act   = sa;
        R          = r_force >= 0 ? 7'(r_force) : 7'($urandom_range(0, 127));
        r_at[cyc + 1] = int'(R);
        last_edge  = cyc + 1;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) drive(1'b0, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    endtask

    // mode: 0 random, 1 all positive, 2 two positive two negative, 3 all negative
    task automatic run_window(input int mode, input int pause_after, input int pause_len, input int abort_at);
        int sum, step;
        logic [3:0] d, sd, a, sa;
        sum = 0;
        for (int n = 1; n <= 16; n++) begin
            if (n == abort_at) begin
                init_v = 1'b0;
                idle(2);
                init_v = 1'b1;
                wt = 0;
                idle(1);
                return;
            end
            d  = mode == 0 ? 4'($urandom) : 4'hF;
            a  = mode == 0 ? 4'($urandom) : 4'hF;
            sa = mode == 0 ? 4'($urandom) : 4'h0;
            sd = mode == 0 ? 4'($urandom) : mode == 1 ? 4'h0 : mode == 2 ? 4'hC : 4'hF;
            for (int i = 0; i < 4; i++)
                if (d[i] && a[i]) sum += (sd[i] ^ sa[i]) ? -1 : 1;
            drive(1'b1, d, sd, a, sa);
            if (n == pause_after) idle(pause_len);
            if (mode == 0 && n < 16 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        step = sum >= 0 ? sum / (1 << LRS) : -((-sum + (1 << LRS) - 1) / (1 << LRS));
        wt = wt - step;
        wt = wt > SMAX ? SMAX : wt < -SMAX ? -SMAX : wt;
        sb.push_back('{last_edge + 1, wt});
        if (mode == 0 && $urandom_range(0, 1) == 0) idle(1);
        else drive(1'b1, 4'hF, 4'h0, 4'hF, 4'h0);
    endtask

    // monitor: every falling edge compare DONE, W, alpha, SIGN_alpha against the model
    always @(negedge CLK) begin
        if (!INIT) begin
            chk("reset_W", int'(W), 0);
            chk("reset_DONE", int'(DONE), 0);
            chk("reset_alpha", int'(alpha), 0);
            chk("reset_SIGN_alpha", int'(SIGN_alpha), 0);
            model_w = 0;
            prev_w  = 0;
        end else begin
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                chk("DONE_pulse", int'(DONE), 1);
                model_w = sb[0].w;
                void'(sb.pop_front());
            end else begin
                chk("DONE_quiet", int'(DONE), 0);
            end
            chk("W", int'(W), model_w);
            if (r_at.exists(cyc)) begin
                chk("alpha", int'(alpha), int'((prev_w < 0 ? -prev_w : prev_w) > r_at[cyc]));
                chk("SIGN_alpha", int'(SIGN_alpha), int'(prev_w < 0));
            end
            prev_w = model_w;
        end
    end

    initial begin
        INIT = 1'b0; EN = 1'b0; delta = '0; SIGN_delta = '0; act = '0; SIGN_act = '0; R = '0;
        idle(3);
        init_v = 1'b1;
        idle(2);
        run_window(1, 0, 0, 8);
        run_window(1, 0, 0, 0);
        idle(3);
        r_force = 15; idle(3);
        r_force = 16; idle(3);
        r_force = -1;
        run_window(2, 0, 0, 0);
        run_window(1, 8, 5, 0);
        for (int k = 0; k < 7; k++) run_window(1, 0, 0, 0);
        for (int k = 0; k < 17; k++) run_window(3, 0, 0, 0);
        for (int k = 0; k < 25; k++) run_window(0, 0, 0, 0);
        idle(4);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
